preg_free_list: RTL and testbench
=================================

Name: preg_free_list

Overview:
- Circular-FIFO free list of physical register tags.
- The rename stage pops up to two free tags per cycle for new destinations.
- The commit/retire stage pushes up to two tags per cycle back: the previous mappings of retired destinations.
- Replaces the ad-hoc free-pool scan with a registered allocator/reclaimer that includes double-free and overflow checking.

Parameters:
- NUM_PREGS, 64, total physical registers (power of two).
- NUM_AREGS, 32, architectural registers; tags 0..NUM_AREGS-1 are mapped at reset.
- PTAG_W, 6, tag width, log2(NUM_PREGS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req_1  in  1  rename slot 1 needs a tag (rd_1 != 0).
- alloc_req_2  in  1  rename slot 2 needs a tag (rd_2 != 0).
- alloc_ready  out  1  enough free tags for the current requests.
- alloc_tag_1  out  PTAG_W  tag for slot 1.
- alloc_tag_2  out  PTAG_W  tag for slot 2.
- rel_valid_1  in  1  commit slot 1 frees rel_tag_1.
- rel_tag_1  in  PTAG_W  tag being freed.
- rel_valid_2  in  1  commit slot 2 frees rel_tag_2.
- rel_tag_2  in  PTAG_W  tag being freed.
- free_count  out  PTAG_W+1  number of tags currently in the list.
- stall_o  out  1  free_count < 2; rename must hold.
- err_o  out  1  sticky error: double free, release of tag 0, or overflow.

Behaviour:
- State:
  - fifo[NUM_PREGS] of tags.
  - head/tail pointers, PTAG_W bits, wrap modulo NUM_PREGS.
  - count register.
  - free_vec[NUM_PREGS], bit=1 means the tag is in the list.
- Reset (async, rst_n=0):
  - fifo[i] = NUM_AREGS+i for i in 0..NUM_PREGS-NUM_AREGS-1; head=0; tail=NUM_PREGS-NUM_AREGS; count=32.
  - free_vec = 1 for tags 32..63, 0 otherwise.
  - err_o=0, stall_o=0, free_count=32.
  - alloc_tag_1=32, alloc_tag_2=33 (combinational from head).
- Reset mid-operation discards all in-flight allocations; the list returns to the reset image immediately.
- Allocation (combinational outputs, registered pop):
  - need = alloc_req_1 + alloc_req_2.
  - alloc_ready = (count >= need).
  - alloc_tag_1 = fifo[head].
  - alloc_tag_2 = alloc_req_1 ? fifo[head+1] : fifo[head].
  - On a clk edge with alloc_ready=1: head += need; count -= need; free_vec cleared for each popped tag.
  - With alloc_ready=0 nothing is popped: all-or-nothing, and the rename stage stalls both slots.
  - need=0: alloc_ready=1, no state change.
- Release (registered push, in order slot 1 then slot 2):
  - Each valid release writes fifo[tail] and advances tail; count and free_vec are updated.
  - Tag 0 (x0 mapping) must never be released. rel_tag==0 with valid sets err_o and is not pushed.
  - Release of a tag whose free_vec bit is already 1 sets err_o and is not pushed.
  - Same tag on both slots in one cycle: slot 1 is pushed; slot 2 is treated as a double free and sets err_o.
- Simultaneous alloc and release in the same cycle:
  - Both occur; count_next = count - need + pushed.
  - Tags released this cycle are not allocatable until the next cycle, since allocation reads registered state only.
- Overflow: a push that would make count exceed NUM_PREGS-NUM_AREGS+... is prevented by the free_vec check. Count is saturated at NUM_PREGS-1 as a defensive measure; any attempt beyond that sets err_o.
- err_o stays asserted until reset.
- free_count and stall_o are registered from count, so they are valid the cycle after the update.

Test Plan:
- Reset then idle: free_count=32, alloc_tag_1=32, alloc_tag_2=33, stall_o=0, err_o=0.
- Pulse both alloc_req for 16 cycles:
  - Tags 32..63 are handed out in order.
  - free_count reaches 0 and stall_o=1.
  - A 17th request gives alloc_ready=0 and head is unchanged.
- With the list empty, release tags 40 and 45 in one cycle:
  - Next cycle free_count=2, alloc_tag_1=40, alloc_tag_2=45.
  - A request with only alloc_req_2=1 returns alloc_tag_2=40.
- Same cycle: allocate 2 while releasing 2, starting from count=2:
  - The new allocations use the old tags.
  - count stays 2.
  - The released tags appear at the head next cycle.
- Error cases:
  - Release tag 50 twice across two cycles → err_o=1 on the second, count unchanged.
  - Release tag 0 → err_o=1.
  - rel_tag_1=rel_tag_2=37 in one cycle → one push, err_o=1.
- Assert rst_n=0 for half a cycle mid-burst → immediate return to the reset image (count=32, head tag 32, err_o=0).

Source files
------------

// File: rtl/preg_free_list_if.sv
// rtl/preg_free_list_if.sv - rename/commit handshake bundle for the physical tag free list
interface preg_free_list_if #(
  parameter int PTAG_W = 6
);
  // rename side
  logic              alloc_req_1;
  logic              alloc_req_2;
  logic              alloc_ready;
  logic [PTAG_W-1:0] alloc_tag_1;
  logic [PTAG_W-1:0] alloc_tag_2;
  // commit side
  logic              rel_valid_1;
  logic [PTAG_W-1:0] rel_tag_1;
  logic              rel_valid_2;
  logic [PTAG_W-1:0] rel_tag_2;
  // status
  logic [PTAG_W:0]   free_count;
  logic              stall_o;
  logic              err_o;

  // Rename/commit pipeline side
  modport master (
    output alloc_req_1, alloc_req_2,
    output rel_valid_1, rel_tag_1, rel_valid_2, rel_tag_2,
    input  alloc_ready, alloc_tag_1, alloc_tag_2,
    input  free_count, stall_o, err_o
  );

  // Free list side
  modport slave (
    input  alloc_req_1, alloc_req_2,
    input  rel_valid_1, rel_tag_1, rel_valid_2, rel_tag_2,
    output alloc_ready, alloc_tag_1, alloc_tag_2,
    output free_count, stall_o, err_o
  );
endinterface

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - circular FIFO of free physical register tags, 2 pops / 2 pushes per cycle
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PTAG_W    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  preg_free_list_if.slave bus
);

  localparam int                NUM_FREE  = NUM_PREGS - NUM_AREGS;
  localparam logic [PTAG_W:0]   RST_CNT   = (PTAG_W+1)'(NUM_FREE);
  localparam logic [PTAG_W:0]   MAX_CNT   = (PTAG_W+1)'(NUM_PREGS - 1);
  localparam logic [PTAG_W:0]   STALL_LVL = (PTAG_W+1)'(2);
  localparam logic [PTAG_W-1:0] RST_TAIL  = PTAG_W'(NUM_FREE);

  logic [PTAG_W-1:0]    r_fifo [NUM_PREGS];
  logic [PTAG_W-1:0]    r_head;
  logic [PTAG_W-1:0]    r_tail;
  logic [PTAG_W:0]      r_count;
  logic [NUM_PREGS-1:0] r_free_vec;
  logic                 r_stall;
  logic                 r_err;

  logic [1:0]           w_need;
  logic                 w_ready;
  logic                 w_pop;
  logic [PTAG_W-1:0]    w_head_p1;
  logic [PTAG_W:0]      w_cnt_after_pop;
  logic [PTAG_W:0]      w_cnt_after_p1;
  logic [PTAG_W:0]      w_count_next;
  logic                 w_ok_1;
  logic                 w_ok_2;
  logic                 w_push_1;
  logic                 w_push_2;
  logic                 w_err_1;
  logic                 w_err_2;
  logic [PTAG_W-1:0]    w_tail_2;

  // Allocation grant and release legality, all from registered state only
  always_comb begin
    w_need          = {1'b0, bus.alloc_req_1} + {1'b0, bus.alloc_req_2};
    w_ready         = r_count >= {{(PTAG_W-1){1'b0}}, w_need};
    w_pop           = w_ready && (w_need != 2'd0);
    w_head_p1       = r_head + 1'b1;
    w_cnt_after_pop = w_pop ? (r_count - {{(PTAG_W-1){1'b0}}, w_need}) : r_count;

    // A tag may only come back if it is not already free and is not x0's mapping
    w_ok_1   = bus.rel_valid_1 && (bus.rel_tag_1 != '0) && !r_free_vec[bus.rel_tag_1];
    w_push_1 = w_ok_1 && (w_cnt_after_pop < MAX_CNT);
    w_err_1  = bus.rel_valid_1 && !w_push_1;

    // Slot 2 repeating slot 1's tag is a double free of the tag slot 1 just returned
    w_ok_2   = bus.rel_valid_2 && (bus.rel_tag_2 != '0) && !r_free_vec[bus.rel_tag_2] &&
               !(w_ok_1 && (bus.rel_tag_1 == bus.rel_tag_2));
    w_cnt_after_p1 = w_cnt_after_pop + {{PTAG_W{1'b0}}, w_push_1};
    w_push_2 = w_ok_2 && (w_cnt_after_p1 < MAX_CNT);
    w_err_2  = bus.rel_valid_2 && !w_push_2;

    w_count_next = w_cnt_after_p1 + {{PTAG_W{1'b0}}, w_push_2};
    w_tail_2     = w_push_1 ? (r_tail + 1'b1) : r_tail;
  end

  assign bus.alloc_ready = w_ready;
  assign bus.alloc_tag_1 = r_fifo[r_head];
  assign bus.alloc_tag_2 = bus.alloc_req_1 ? r_fifo[w_head_p1] : r_fifo[r_head];
  assign bus.free_count  = r_count;
  assign bus.stall_o     = r_stall;
  assign bus.err_o       = r_err;

  // Tag storage: reset image holds the unmapped tags, releases append at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_fifo[i] <= (i < NUM_FREE) ? PTAG_W'(NUM_AREGS + i) : '0;
      end
    end else begin
      if (w_push_1) r_fifo[r_tail]   <= bus.rel_tag_1;
      if (w_push_2) r_fifo[w_tail_2] <= bus.rel_tag_2;
    end
  end

  // Pointers, occupancy, membership vector and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= RST_TAIL;
      r_count <= RST_CNT;
      r_stall <= (RST_CNT < STALL_LVL);
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_free_vec[i] <= (i >= NUM_AREGS);
      end
    end else begin
      if (w_pop) r_head <= r_head + PTAG_W'(w_need);
      r_tail  <= w_tail_2 + {{(PTAG_W-1){1'b0}}, w_push_2};
      r_count <= w_count_next;
      r_stall <= (w_count_next < STALL_LVL);
      r_err   <= r_err | w_err_1 | w_err_2;
      if (w_pop)                     r_free_vec[r_fifo[r_head]]    <= 1'b0;
      if (w_pop && w_need == 2'd2)   r_free_vec[r_fifo[w_head_p1]] <= 1'b0;
      if (w_push_1)                  r_free_vec[bus.rel_tag_1]     <= 1'b1;
      if (w_push_2)                  r_free_vec[bus.rel_tag_2]     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - directed and randomized checks of preg_free_list against a queue model
module tb_preg_free_list;

  logic clk;
  logic rst_n;

  preg_free_list_if #(.PTAG_W(6)) bus ();

  preg_free_list #(
    .NUM_PREGS(64),
    .NUM_AREGS(32),
    .PTAG_W   (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: list contents in order, tags held by the pipeline, membership, error
  int q[$];
  int out_q[$];
  bit free_m[64];
  bit err_m;

  int n_checks = 0;
  int n_errors = 0;

  logic       g_ready;
  logic [5:0] g_tag1;
  logic [5:0] g_tag2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    out_q.delete();
    for (int i = 0; i < 64; i++) free_m[i] = 1'b0;
    for (int i = 32; i < 64; i++) begin
      q.push_back(i);
      free_m[i] = 1'b1;
    end
    for (int i = 1; i < 32; i++) out_q.push_back(i);
    err_m = 1'b0;
  endtask

  task automatic model_push(input int t);
    q.push_back(t);
    free_m[t] = 1'b1;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] == t) begin
        out_q.delete(i);
        break;
      end
    end
  endtask

  task automatic check_status();
    check("free_count", 32'(bus.free_count), q.size());
    check("stall_o", 32'(bus.stall_o), 32'(q.size() < 2));
    check("err_o", 32'(bus.err_o), 32'(err_m));
  endtask

  // one cycle: drive at edge+1, check combinational outputs, clock, update model, check state
  task automatic step(input bit r1, input bit r2, input bit v1, input int t1,
                      input bit v2, input int t2);
    int  need;
    bit  legal1;
    bit  legal2;
    bit  free_pre[64];
    bus.alloc_req_1 = r1;
    bus.alloc_req_2 = r2;
    bus.rel_valid_1 = v1;
    bus.rel_tag_1   = 6'(t1);
    bus.rel_valid_2 = v2;
    bus.rel_tag_2   = 6'(t2);
    #1;
    need    = int'(r1) + int'(r2);
    g_ready = bus.alloc_ready;
    g_tag1  = bus.alloc_tag_1;
    g_tag2  = bus.alloc_tag_2;
    check("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() >= need));
    if (q.size() >= 1) check("alloc_tag_1", 32'(bus.alloc_tag_1), q[0]);
    if (r1 && q.size() >= 2) check("alloc_tag_2", 32'(bus.alloc_tag_2), q[1]);
    else if (!r1 && q.size() >= 1) check("alloc_tag_2", 32'(bus.alloc_tag_2), q[0]);
    @(posedge clk);
    free_pre = free_m;
    if (q.size() >= need) begin
      for (int k = 0; k < need; k++) begin
        int t;
        t = q.pop_front();
        free_m[t] = 1'b0;
        out_q.push_back(t);
      end
    end
    legal1 = v1 && (t1 != 0) && !free_pre[t1];
    if (legal1 && q.size() < 63) model_push(t1);
    else if (v1) err_m = 1'b1;
    legal2 = v2 && (t2 != 0) && !free_pre[t2] && !(legal1 && t1 == t2);
    if (legal2 && q.size() < 63) model_push(t2);
    else if (v2) err_m = 1'b1;
    #1;
    check_status();
  endtask

  task automatic full_reset();
    bus.alloc_req_1 = 1'b0;
    bus.alloc_req_2 = 1'b0;
    bus.rel_valid_1 = 1'b0;
    bus.rel_valid_2 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int  fc;
    bit  r1;
    bit  r2;
    bit  v1;
    bit  v2;
    int  t1;
    int  t2;
    int  i1;
    int  i2;

    rst_n = 1'b0;
    bus.alloc_req_1 = 1'b0;
    bus.alloc_req_2 = 1'b0;
    bus.rel_valid_1 = 1'b0;
    bus.rel_tag_1   = '0;
    bus.rel_valid_2 = 1'b0;
    bus.rel_tag_2   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // reset image
    check("rst_free_count", 32'(bus.free_count), 32);
    check("rst_stall", 32'(bus.stall_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_tag1", 32'(bus.alloc_tag_1), 32);
    step(0, 0, 0, 0, 0, 0);

    // drain the list two tags per cycle
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 0, 0, 0, 0);
      check("drain_tag1", 32'(g_tag1), 32'(32 + 2 * k));
      check("drain_tag2", 32'(g_tag2), 32'(33 + 2 * k));
    end
    check("empty_count", 32'(bus.free_count), 0);
    check("empty_stall", 32'(bus.stall_o), 1);
    step(1, 1, 0, 0, 0, 0);
    check("empty_ready", 32'(g_ready), 0);

    // refill from empty, head must still be where the drain left it
    step(0, 0, 1, 40, 1, 45);
    check("refill_count", 32'(bus.free_count), 2);
    step(0, 1, 0, 0, 0, 0);
    check("slot2_only_tag", 32'(g_tag2), 40);
    step(0, 0, 1, 41, 0, 0);

    // allocate two while releasing two
    step(1, 1, 1, 32, 1, 33);
    check("bypass_tag1", 32'(g_tag1), 45);
    check("bypass_tag2", 32'(g_tag2), 41);
    check("bypass_count", 32'(bus.free_count), 2);
    step(0, 0, 0, 0, 0, 0);
    check("bypass_head", 32'(g_tag1), 32);
    step(1, 1, 0, 0, 0, 0);
    check("bypass_next", 32'(g_tag2), 33);

    // double free across cycles
    step(0, 0, 1, 50, 0, 0);
    fc = int'(bus.free_count);
    step(0, 0, 1, 50, 0, 0);
    check("dbl_err", 32'(bus.err_o), 1);
    check("dbl_count", 32'(bus.free_count), 32'(fc));

    // release of x0's tag
    full_reset();
    check("rst2_err", 32'(bus.err_o), 0);
    step(0, 0, 1, 0, 0, 0);
    check("tag0_err", 32'(bus.err_o), 1);
    check("tag0_count", 32'(bus.free_count), 32);

    // same tag on both slots
    full_reset();
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 37, 1, 37);
    check("same_err", 32'(bus.err_o), 1);
    check("same_count", 32'(bus.free_count), 27);

    // half-cycle reset in the middle of an allocation burst
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    bus.alloc_req_1 = 1'b1;
    bus.alloc_req_2 = 1'b1;
    rst_n = 1'b0;
    #3;
    check("mid_rst_count", 32'(bus.free_count), 32);
    check("mid_rst_tag1", 32'(bus.alloc_tag_1), 32);
    check("mid_rst_tag2", 32'(bus.alloc_tag_2), 33);
    check("mid_rst_err", 32'(bus.err_o), 0);
    check("mid_rst_stall", 32'(bus.stall_o), 0);
    #2;
    rst_n = 1'b1;
    bus.alloc_req_1 = 1'b0;
    bus.alloc_req_2 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_status();

    // randomized legal traffic
    for (int n = 0; n < 400; n++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      t1 = int'($urandom_range(0, 63));
      t2 = int'($urandom_range(0, 63));
      v1 = 1'b0;
      v2 = 1'b0;
      if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        i1 = int'($urandom_range(0, out_q.size() - 1));
        t1 = out_q[i1];
        v1 = 1'b1;
        if (out_q.size() > 1 && $urandom_range(0, 1) != 0) begin
          i2 = int'($urandom_range(0, out_q.size() - 2));
          if (i2 >= i1) i2++;
          t2 = out_q[i2];
          v2 = 1'b1;
        end
      end
      step(r1, r2, v1, t1, v2, t2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
